// File: rtl/pigasus_hash_pkg.sv
// Shared definitions for the mul_hash lanes and their downstream window combiner.
// HASH_MULT lives here so every mul_hash user sees one constant.
package pigasus_hash_pkg;

  localparam logic [63:0] HASH_MULT = 64'h0b4e0ef37bc32127;

  typedef logic [63:0] prod_t;
  typedef logic [23:0] pp_t;

  // Rebuild byte*HASH_MULT mod 2^64 from the four 16b-slice partial products.
  function automatic prod_t rebuild_product(pp_t ab0, pp_t ab1, pp_t ab2, pp_t ab3);
    return prod_t'(ab0) + (prod_t'(ab1) << 16) + (prod_t'(ab2) << 32) + (prod_t'(ab3) << 48);
  endfunction

endpackage

// File: rtl/mul_hash_window_sum.sv
// Combinational shift-add of WIN per-byte products into one 64b window hash.
// win[k*64+:64] is the product k bytes before the newest; the newest weighs <<0.
module mul_hash_window_sum
  import pigasus_hash_pkg::*;
#(
  parameter int WIN = 8
) (
  input  logic [WIN*64-1:0] win,
  output prod_t             sum
);

  // NOTE: always_comb accumulates with blocking '=' and starts from a default,
  // so every path assigns sum and no latch can be inferred.
  always_comb begin
    sum = '0;
    for (int k = 0; k < WIN; k++) begin
      sum = sum + (win[k*64 +: 64] << (8 * k));
    end
  end

endmodule

// File: rtl/mul_hash_window_combine.sv
// Three-stage pipeline: rebuild per-lane products, sum WIN-byte windows across
// beat boundaries using per-packet history, then emit the top HASH_BITS per lane.
module mul_hash_window_combine
  import pigasus_hash_pkg::*;
#(
  parameter int NBYTE     = 8,
  parameter int WIN       = 8,
  parameter int HASH_BITS = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [$clog2(NBYTE)-1:0]   in_empty,
  input  logic [NBYTE*24-1:0]        in_ab0,
  input  logic [NBYTE*24-1:0]        in_ab1,
  input  logic [NBYTE*24-1:0]        in_ab2,
  input  logic [NBYTE*24-1:0]        in_ab3,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [NBYTE-1:0]           out_mask,
  output logic [NBYTE*HASH_BITS-1:0] out_hash
);

  // HIST is at least 1 so WIN=1 still elaborates; the extra entry is never weighed.
  localparam int HIST = (WIN > 1) ? WIN - 1 : 1;
  localparam int CW   = $clog2(WIN + 1);

  // ---------------- S1: product rebuild ----------------
  logic [NBYTE-1:0] lane_valid;
  prod_t            prod [NBYTE];
  prod_t            p1   [NBYTE];
  logic             v1, last1;
  logic [NBYTE-1:0] lv1;

  always_comb begin
    for (int i = 0; i < NBYTE; i++) begin
      lane_valid[i] = !(in_last && (i >= NBYTE - int'(in_empty)));
      prod[i] = rebuild_product(in_ab0[i*24 +: 24], in_ab1[i*24 +: 24],
                                in_ab2[i*24 +: 24], in_ab3[i*24 +: 24]);
    end
  end

  // NOTE: the data registers are reset along with the valids so that every
  // output, not just out_valid, reads 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      lv1   <= '0;
      for (int i = 0; i < NBYTE; i++) p1[i] <= '0;
    end else begin
      v1    <= in_valid;
      last1 <= in_valid && in_last;
      lv1   <= in_valid ? lane_valid : '0;
      // Empty lanes carry zero so they can never pollute history.
      for (int i = 0; i < NBYTE; i++) p1[i] <= lane_valid[i] ? prod[i] : '0;
    end
  end

  // ---------------- S2: window sums, history, byte count ----------------
  prod_t             hist [HIST];   // hist[0] is the most recent previous product
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  prod_t             ext  [NBYTE+HIST];
  logic [WIN*64-1:0] win_bus [NBYTE];
  prod_t             h_comb  [NBYTE];
  logic [NBYTE-1:0]  mask_comb;
  prod_t             h2 [NBYTE];
  logic              v2, last2;
  logic [NBYTE-1:0]  mask2;

  always_comb begin
    for (int m = 0; m < HIST; m++)  ext[HIST-1-m] = hist[m];
    for (int i = 0; i < NBYTE; i++) ext[HIST+i]   = p1[i];
    for (int i = 0; i < NBYTE; i++) begin
      win_bus[i] = '0;
      for (int k = 0; k < WIN; k++) win_bus[i][k*64 +: 64] = ext[HIST+i-k];
      mask_comb[i] = lv1[i] && (int'(cnt) + i + 1 >= WIN);
    end
    cnt_next = (int'(cnt) + NBYTE >= WIN) ? CW'(WIN) : CW'(int'(cnt) + NBYTE);
  end

  for (genvar g = 0; g < NBYTE; g++) begin : g_lane
    mul_hash_window_sum #(.WIN(WIN)) u_sum (
      .win (win_bus[g]),
      .sum (h_comb[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      mask2 <= '0;
      cnt   <= '0;
      for (int i = 0; i < NBYTE; i++) h2[i]   <= '0;
      for (int m = 0; m < HIST; m++)  hist[m] <= '0;
    end else begin
      v2    <= v1;
      last2 <= last1;
      mask2 <= mask_comb;
      for (int i = 0; i < NBYTE; i++) h2[i] <= h_comb[i];
      // Idle cycles leave history and count alone; a last beat starts a fresh packet.
      if (v1) begin
        if (last1) begin
          cnt <= '0;
          for (int m = 0; m < HIST; m++) hist[m] <= '0;
        end else begin
          cnt <= cnt_next;
          for (int m = 0; m < HIST; m++) hist[m] <= ext[NBYTE+HIST-1-m];
        end
      end
    end
  end

  // ---------------- S3: index extraction ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_mask  <= '0;
      out_hash  <= '0;
    end else begin
      out_valid <= v2;
      out_last  <= last2;
      out_mask  <= mask2;
      for (int i = 0; i < NBYTE; i++) out_hash[i*HASH_BITS +: HASH_BITS] <= h2[i][63 -: HASH_BITS];
    end
  end

endmodule

// File: tb/tb_mul_hash_window_combine.sv
// Scoreboard bench: byte-level window model feeds an expected queue; a negedge
// monitor pops and compares whenever the DUT presents a result beat.
module tb_mul_hash_window_combine;
  import pigasus_hash_pkg::*;

  localparam int NBYTE = 8;
  localparam int WIN   = 8;
  localparam int HB    = 13;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_last;
  logic [2:0]         in_empty;
  logic [NBYTE*24-1:0] in_ab0, in_ab1, in_ab2, in_ab3;
  logic               out_valid, out_last;
  logic [NBYTE-1:0]   out_mask;
  logic [NBYTE*HB-1:0] out_hash;

  mul_hash_window_combine #(.NBYTE(NBYTE), .WIN(WIN), .HASH_BITS(HB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_empty(in_empty),
    .in_ab0(in_ab0), .in_ab1(in_ab1), .in_ab2(in_ab2), .in_ab3(in_ab3),
    .out_valid(out_valid), .out_last(out_last), .out_mask(out_mask), .out_hash(out_hash)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int              cyc;
    logic            last;
    logic [NBYTE-1:0] mask;
    logic [NBYTE*HB-1:0] hash;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq[$];     // bytes of the current packet, newest at the back
  int         pcnt = 0;  // valid bytes seen in the current packet
  int         total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one beat and pushes the model's expectation for it.
  task automatic send(input logic [63:0] bytes, input logic last, input int empty);
    exp_t        e;
    logic [63:0] hm, wv, pr;
    logic [7:0]  b;
    @(posedge clk); #1;
    hm = HASH_MULT;
    in_valid = 1'b1;
    in_last  = last;
    in_empty = 3'(empty);
    e.cyc  = cyc;
    e.last = last;
    e.mask = '0;
    e.hash = '0;
    for (int i = 0; i < NBYTE; i++) begin
      b = bytes[i*8 +: 8];
      in_ab0[i*24 +: 24] = 24'(b) * 24'(hm[15:0]);
      in_ab1[i*24 +: 24] = 24'(b) * 24'(hm[31:16]);
      in_ab2[i*24 +: 24] = 24'(b) * 24'(hm[47:32]);
      in_ab3[i*24 +: 24] = 24'(b) * 24'(hm[63:48]);
      if (!(last && i >= NBYTE - empty)) begin
        mq.push_back(b);
        if (mq.size() > WIN) void'(mq.pop_front());
        pcnt++;
        wv = '0;
        for (int k = 0; k < mq.size(); k++) wv = wv | (64'(mq[mq.size()-1-k]) << (8 * k));
        pr = hm * wv;
        e.mask[i] = (pcnt >= WIN);
        e.hash[i*HB +: HB] = pr[63 -: HB];
      end
    end
    if (last) begin
      mq.delete();
      pcnt = 0;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_empty = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    sb.delete();
    mq.delete();
    pcnt = 0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_mask", 64'(out_mask), 64'd0);
    check("rst_hash", 64'(|out_hash), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compares each presented beat against the head of the scoreboard.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 64'd1, 64'd0);
        end else begin
          me = sb.pop_front();
          check("latency", 64'(cyc), 64'(me.cyc + 3));
          check("last", 64'(out_last), 64'(me.last));
          check("mask", 64'(out_mask), 64'(me.mask));
          for (int i = 0; i < NBYTE; i++)
            if (me.mask[i]) check($sformatf("hash_lane%0d", i), 64'(out_hash[i*HB +: HB]), 64'(me.hash[i*HB +: HB]));
        end
      end else if (sb.size() > 0 && sb[0].cyc + 3 <= cyc) begin
        me = sb.pop_front();
        check("missing_valid", 64'd0, 64'd1);
      end
    end
  end

  logic [63:0] rb;
  int          empty_r;
  logic        last_r;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_empty = '0;
    in_ab0 = '0; in_ab1 = '0; in_ab2 = '0; in_ab3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_hash", 64'(|out_hash), 64'd0);
    rst_n = 1'b1;

    // Bytes 01..08 in lanes 0..7, single last beat.
    send(64'h0807060504030201, 1'b1, 0);
    idle(4);

    // All-zero packet of three beats.
    send(64'd0, 1'b0, 0);
    send(64'd0, 1'b0, 0);
    send(64'd0, 1'b1, 0);
    idle(4);

    // 16B packet with a two-cycle gap, then the same without the gap.
    send(64'h0807060504030201, 1'b0, 0); idle(2);
    send(64'h100f0e0d0c0b0a09, 1'b1, 0); idle(2);
    send(64'h0807060504030201, 1'b0, 0);
    send(64'h100f0e0d0c0b0a09, 1'b1, 0);
    idle(4);

    // Last beat with three empty lanes, then a new packet.
    send(64'h1122334455667788, 1'b0, 0);
    send(64'hffeeddccbbaa9988, 1'b1, 3);
    send(64'h0102030405060708, 1'b1, 0);
    idle(4);

    // Back-to-back packets A then B.
    send(64'hdeadbeefcafef00d, 1'b1, 0);
    send(64'h0807060504030201, 1'b0, 0);
    send(64'h1111111111111111, 1'b1, 0);
    idle(4);

    // Reset in the middle of a packet while results are in flight.
    send(64'h0123456789abcdef, 1'b0, 0);
    send(64'h0123456789abcdef, 1'b0, 0);
    send(64'h0123456789abcdef, 1'b0, 0);
    send(64'h0123456789abcdef, 1'b0, 0);
    do_reset();
    idle(6);
    send(64'h0807060504030201, 1'b1, 0);
    idle(4);

    // Random soak.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
      rb      = {$urandom(), $urandom()};
      last_r  = ($urandom_range(5) == 0);
      empty_r = last_r ? int'($urandom_range(7)) : 0;
      send(rb, last_r, empty_r);
    end
    idle(10);
    check("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
